// File: rtl/block_mem_ctrl.sv
// block_mem_ctrl: block-aligned memory with fixed access latency; in: req_valid/req_write/req_addr/wdata/wmask, out: req_ready/busy/done/rdata
module block_mem_ctrl #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int DEPTH           = 256,
  parameter int ADDR_W          = 32,
  parameter int LATENCY         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0] wdata,
  input  logic [WORDS_PER_BLOCK-1:0]        wmask,
  output logic                              req_ready,
  output logic                              busy,
  output logic                              done,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] rdata
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int BLK_W = WORD_W * WORDS_PER_BLOCK;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic wr;
  logic [IDX_W-1:0] base, idx;
  logic [BLK_W-1:0] wbuf;
  logic [WORDS_PER_BLOCK-1:0] mbuf;
  logic accept, commit, unused;
  assign idx = req_addr[IDX_W+1:2] & ~IDX_W'(WORDS_PER_BLOCK - 1);
  assign unused = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
  assign accept = state == IDLE && req_valid;
  assign commit = state == ACCESS && cnt == '0;
  always_comb begin
    req_ready = state == IDLE;
    busy = state == ACCESS;
    done = state == DONE;
    state_nxt = accept ? ACCESS : commit ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_W'(LATENCY - 1);
        wr <= req_write;
        base <= idx;
        wbuf <= wdata;
        mbuf <= wmask;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && !wr)
        for (int i = 0; i < WORDS_PER_BLOCK; i++)
          rdata[i*WORD_W +: WORD_W] <= mem[base | IDX_W'(i)];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && commit && wr)
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
        if (mbuf[i]) mem[base | IDX_W'(i)] <= wbuf[i*WORD_W +: WORD_W];
  end
endmodule

// File: tb/tb_block_mem_ctrl.sv
module tb_block_mem_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic req_valid = 0, req_valid1 = 0, req_write = 0;
  logic [31:0] req_addr = 0;
  logic [127:0] wdata = 0;
  logic [3:0] wmask = 0;
  logic req_ready, busy, done, req_ready1, busy1, done1;
  logic [127:0] rdata, rdata1;
  int checks = 0, failures = 0;
  localparam logic [127:0] B20 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] B50 = 128'h00000000_000000A2_00000000_000000A0;
  localparam logic [127:0] D50 = 128'h000000D3_000000D2_000000D1_000000D0;

  always #5 clk = ~clk;

  block_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .wdata(wdata), .wmask(wmask),
    .req_ready(req_ready), .busy(busy), .done(done), .rdata(rdata)
  );

  block_mem_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_write(req_write),
    .req_addr(req_addr), .wdata(wdata), .wmask(wmask),
    .req_ready(req_ready1), .busy(busy1), .done(done1), .rdata(rdata1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [127:0] d, input logic [3:0] m);
    int n;
    @(negedge clk);
    req_write = w; req_addr = a; wdata = d; wmask = m; req_valid = 1;
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!done && n < 20) begin
      chk("ready_low_in_access", req_ready, 0);
      chk("busy_in_access", busy, 1);
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 5);
    chk("ready_low_in_done", req_ready, 0);
    @(negedge clk);
    chk("done_one_wide", done, 0);
    chk("ready_after_done", req_ready, 1);
  endtask

  task automatic req1(input logic [31:0] a, input logic [127:0] d);
    @(negedge clk);
    req_write = 1; req_addr = a; wdata = d; wmask = 4'hF; req_valid1 = 1;
    @(negedge clk);
    req_valid1 = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [127:0] held;
    logic [31:0] addrs [4];
    logic [127:0] exps [4];
    int dones;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    reset = 0;
    // preload through the write port
    req(1, 32'h20, B20, 4'hF);
    chk("mem8", dut.mem[8], 32'h11);
    chk("mem11", dut.mem[11], 32'h44);
    req(1, 32'h50, 128'h0, 4'hF);
    // basic read
    req(0, 32'h20, 0, 4'h0);
    chk("read_20", rdata, B20);
    // masked write leaves rdata alone
    req(1, 32'h50, 128'h000000A3_000000A2_000000A1_000000A0, 4'b0101);
    chk("rdata_kept_on_write", rdata, B20);
    chk("mem20", dut.mem[20], 32'hA0);
    chk("mem21", dut.mem[21], 32'h0);
    chk("mem22", dut.mem[22], 32'hA2);
    chk("mem23", dut.mem[23], 32'h0);
    req(0, 32'h54, 0, 4'h0);
    chk("read_54_unaligned", rdata, B50);
    req(0, 32'h420, 0, 4'h0);
    chk("read_wrap_420", rdata, B20);
    // busy rejection: second request held during ACCESS
    req(0, 32'h50, 0, 4'h0);
    @(negedge clk);
    req_write = 0; req_addr = 32'h20; req_valid = 1;
    @(negedge clk);
    req_addr = 32'h50;
    dones = 0;
    for (int k = 0; k < 25 && dones < 2; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk(dones == 1 ? "busy_rej_first" : "busy_rej_second", rdata, dones == 1 ? B20 : B50);
        if (dones == 2) req_valid = 0;
      end
    end
    req_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("busy_rej_done_count", dones, 2);
    // reset in the middle of a write
    @(negedge clk);
    req_write = 1; req_addr = 32'h20; wdata = {4{32'hFFFF_FFFF}}; wmask = 4'hF; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_busy", busy, 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    chk("rst_mid_mem8", dut.mem[8], 32'h11);
    chk("rst_mid_mem11", dut.mem[11], 32'h44);
    // LATENCY=1 back-to-back reads on dut1
    req1(32'h20, B20);
    req1(32'h50, D50);
    addrs = '{32'h20, 32'h50, 32'h420, 32'h54};
    exps = '{B20, D50, B20, D50};
    @(negedge clk);
    req_write = 0; req_addr = addrs[0]; req_valid1 = 1;
    for (int k = 0; k < 12; k++) begin
      chk("l1_ready", req_ready1, k % 3 == 0);
      chk("l1_done", done1, k % 3 == 2);
      if (k % 3 == 2) begin
        chk("l1_rdata", rdata1, exps[k/3]);
        if (k < 11) req_addr = addrs[k/3 + 1];
      end
      held = rdata1;
      @(negedge clk);
      if (k % 3 == 2) chk("l1_rdata_stable", rdata1, held);
    end
    req_valid1 = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
